// File: rtl/mux5_rr_sched.sv
// mux5_rr_sched: round-robin owner of a shared 3-bit 5:1 select datapath.
// One requester holds the mux for at most HOLD_CYCLES cycles, or less if it
// drops its request. Hand-over to the next requester happens on the release
// edge itself, so there is no idle cycle between owners.
module mux5_rr_sched #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [4:0]  req,
  input  logic [14:0] din,
  output logic [4:0]  grant,
  output logic [2:0]  sel,
  output logic [2:0]  dout,
  output logic        dout_valid,
  output logic        done
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] LP_HOLD = 3'(HOLD_CYCLES);

  // Modulo-5 increment on a 3-bit source index.
  function automatic logic [2:0] f_inc5(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  state_t     r_state, w_state_n;
  logic [4:0] r_grant, w_grant_n;
  logic [2:0] r_sel,   w_sel_n;
  logic [2:0] r_cnt,   w_cnt_n;
  logic [2:0] r_ptr,   w_ptr_n;
  logic       r_done,  w_done_n;

  logic [2:0] w_ptr_rel;   // pointer the scan uses once the owner releases
  logic [2:0] w_arb_ptr;   // start position of this cycle's scan
  logic [2:0] w_idx;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_release;

  assign w_ptr_rel = f_inc5(r_sel);
  assign w_arb_ptr = (r_state == HOLD) ? w_ptr_rel : r_ptr;
  assign w_release = !req[r_sel] || (r_cnt == LP_HOLD);

  // Round-robin scan: first requester at or after w_arb_ptr, wrapping 4->0.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = w_arb_ptr;
    for (int k = 0; k < 5; k++) begin
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = f_inc5(w_idx);
    end
  end

  // Next-state and registered-output logic for the IDLE/HOLD controller.
  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_sel_n   = r_sel;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_done_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_n = 5'(1) << w_win;
          w_sel_n   = w_win;
          w_cnt_n   = 3'd1;
          w_state_n = HOLD;
        end
      end
      HOLD: begin
        if (w_release) begin
          // Release and re-arbitrate from the slot after the old owner.
          w_done_n = 1'b1;
          w_ptr_n  = w_ptr_rel;
          if (w_found) begin
            w_grant_n = 5'(1) << w_win;
            w_sel_n   = w_win;
            w_cnt_n   = 3'd1;
          end else begin
            w_grant_n = 5'd0;
            w_cnt_n   = 3'd0;
            w_state_n = IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State registers; synchronous reset wins over everything, mid-grant too.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 5'd0;
      r_sel   <= 3'd0;
      r_cnt   <= 3'd0;
      r_ptr   <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_sel   <= w_sel_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_done  <= w_done_n;
    end
  end

  assign grant      = r_grant;
  assign sel        = r_sel;
  assign done       = r_done;
  assign dout_valid = |r_grant;

  // Data path: slice of the granted source, forced to zero when nobody owns it.
  always_comb begin
    dout = 3'b000;
    if (dout_valid) begin
      case (r_sel)
        3'd0:    dout = din[2:0];
        3'd1:    dout = din[5:3];
        3'd2:    dout = din[8:6];
        3'd3:    dout = din[11:9];
        3'd4:    dout = din[14:12];
        default: dout = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_mux5_rr_sched.sv
// Bench for mux5_rr_sched: directed scenarios plus a random run, all checked
// against a transaction-level model (current owner, dwell count, rr start).
module tb_mux5_rr_sched;

  localparam int HOLD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  req = '0;
  logic [14:0] din = '0;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic [2:0]  dout;
  logic        dout_valid;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  mux5_rr_sched #(.HOLD_CYCLES(HOLD)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .din(din),
    .grant(grant), .sel(sel), .dout(dout), .dout_valid(dout_valid), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: who owns the mux, how long, where the next scan starts.
  int m_owner = -1;
  int m_sel   = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_done  = 0;
  logic [12:0] exp_v;   // {grant, sel, dout, dout_valid, done}

  function automatic int pick(input int p, input logic [4:0] r);
    for (int k = 0; k < 5; k++) begin
      if (r[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [4:0] r, input bit rs);
    int w;
    if (rs) begin
      m_owner = -1; m_sel = 0; m_cnt = 0; m_ptr = 0; m_done = 0;
    end else if (m_owner < 0) begin
      m_done = 0;
      w = pick(m_ptr, r);
      if (w >= 0) begin m_owner = w; m_sel = w; m_cnt = 1; end
    end else if (!r[m_owner] || m_cnt == HOLD) begin
      m_done = 1;
      m_ptr  = (m_owner + 1) % 5;
      w = pick(m_ptr, r);
      if (w >= 0) begin m_owner = w; m_sel = w; m_cnt = 1; end
      else m_owner = -1;
    end else begin
      m_done = 0;
      m_cnt++;
    end
  endtask

  function automatic logic [12:0] model_out(input logic [14:0] d);
    logic [4:0] g;
    logic [2:0] o;
    g = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    o = (m_owner < 0) ? 3'd0 : d[3*m_owner +: 3];
    return {g, 3'(m_sel), o, (m_owner >= 0), m_done};
  endfunction

  // One clock: drive inputs, let the edge happen, advance model, settle.
  task automatic cyc(input logic [4:0] r, input logic [14:0] d, input bit rs);
    req = r; din = d; reset = rs;
    @(posedge CLOCK_50);
    model_step(r, rs);
    exp_v = model_out(d);
    #1;
  endtask

  task automatic test_reset;
    cyc(5'd0, 15'h1234, 1'b1);
    cyc(5'd0, 15'h1234, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(5'd0, 15'($urandom), 1'b0);
      n_chk++;
      if ({grant, sel, dout, dout_valid, done} !== 13'd0)
        $display("FAIL reset_idle cyc%0d: got g=%b s=%0d o=%b v=%b d=%b want all zero",
                 i, grant, sel, dout, dout_valid, done);
      else n_pass++;
    end
  endtask

  task automatic test_single;
    logic [14:0] d;
    int ndone = 0;
    cyc(5'd0, 15'd0, 1'b1);
    d = 15'($urandom);
    d[8:6] = 3'b101;
    for (int i = 1; i <= 13; i++) begin
      cyc(5'b00100, d, 1'b0);
      n_chk++;
      if ({grant, sel, dout, dout_valid, done} !== exp_v)
        $display("FAIL single cyc%0d: got %b want %b", i, {grant, sel, dout, dout_valid, done}, exp_v);
      else n_pass++;
      n_chk++;
      if (grant !== 5'b00100 || sel !== 3'd2 || dout !== 3'b101)
        $display("FAIL single_hold cyc%0d: got g=%b s=%0d o=%b want 00100/2/101", i, grant, sel, dout);
      else n_pass++;
      if (done === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone != 3) $display("FAIL single_done_count: got %0d want 3", ndone);
    else n_pass++;
  endtask

  task automatic test_all_five;
    int seq[$];
    int want[5] = '{1, 2, 3, 4, 0};
    cyc(5'd0, 15'd0, 1'b1);
    for (int i = 1; i <= 21; i++) begin
      cyc(5'b11111, 15'($urandom), 1'b0);
      n_chk++;
      if ({grant, sel, dout, dout_valid, done} !== exp_v)
        $display("FAIL all5 cyc%0d: got %b want %b", i, {grant, sel, dout, dout_valid, done}, exp_v);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (sel !== 3'd0) $display("FAIL all5_first: got sel=%0d want 0", sel);
        else n_pass++;
      end
      if (done === 1'b1) seq.push_back(int'(sel));
    end
    n_chk++;
    if (seq.size() != 5) $display("FAIL all5_switches: got %0d switches want 5", seq.size());
    else begin
      bit ok = 1;
      foreach (want[k]) if (seq[k] != want[k]) ok = 0;
      if (!ok) $display("FAIL all5_order: got %p want %p", seq, want);
      else n_pass++;
    end
  endtask

  task automatic test_early_release;
    cyc(5'd0, 15'd0, 1'b1);
    cyc(5'b01000, 15'h7abc, 1'b0);
    cyc(5'b01001, 15'h7abc, 1'b0);
    n_chk++;
    if (grant !== 5'b01000 || done !== 1'b0)
      $display("FAIL early_held: got g=%b d=%b want 01000/0", grant, done);
    else n_pass++;
    cyc(5'b00001, 15'h7abc, 1'b0);
    n_chk++;
    if (grant !== 5'b00001 || sel !== 3'd0 || done !== 1'b1 || dout !== 3'b100)
      $display("FAIL early_release: got g=%b s=%0d d=%b o=%b want 00001/0/1/100",
               grant, sel, done, dout);
    else n_pass++;
    cyc(5'b00001, 15'h7abc, 1'b0);
    n_chk++;
    if (done !== 1'b0) $display("FAIL early_done_pulse: got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_fairness;
    int seq[$];
    int want[4] = '{1, 4, 1, 4};
    cyc(5'd0, 15'd0, 1'b1);
    for (int i = 1; i <= 13; i++) begin
      cyc(5'b10010, 15'($urandom), 1'b0);
      n_chk++;
      if ({grant, sel, dout, dout_valid, done} !== exp_v)
        $display("FAIL fair cyc%0d: got %b want %b", i, {grant, sel, dout, dout_valid, done}, exp_v);
      else n_pass++;
      if (i == 1 || done === 1'b1) seq.push_back(int'(sel));
    end
    n_chk++;
    if (seq.size() != 4) $display("FAIL fair_count: got %0d want 4", seq.size());
    else begin
      bit ok = 1;
      foreach (want[k]) if (seq[k] != want[k]) ok = 0;
      if (!ok) $display("FAIL fair_order: got %p want %p", seq, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    cyc(5'd0, 15'd0, 1'b1);
    cyc(5'b00100, 15'h0155, 1'b0);
    cyc(5'b00100, 15'h0155, 1'b0);
    n_chk++;
    if (grant !== 5'b00100) $display("FAIL mid_pre: got g=%b want 00100", grant);
    else n_pass++;
    cyc(5'b00100, 15'h0155, 1'b1);
    n_chk++;
    if (grant !== 5'd0 || sel !== 3'd0 || done !== 1'b0 || dout_valid !== 1'b0)
      $display("FAIL mid_reset: got g=%b s=%0d d=%b v=%b want 0/0/0/0", grant, sel, done, dout_valid);
    else n_pass++;
    cyc(5'b11111, 15'h0155, 1'b0);
    n_chk++;
    if (grant !== 5'b00001 || sel !== 3'd0)
      $display("FAIL mid_after: got g=%b s=%0d want 00001/0", grant, sel);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [4:0] r;
    bit rs;
    cyc(5'd0, 15'd0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs = ($urandom_range(0, 49) == 0);
      cyc(r, 15'($urandom), rs);
      n_chk++;
      if ({grant, sel, dout, dout_valid, done} !== exp_v)
        $display("FAIL rand cyc%0d: req=%b rst=%b got %b want %b",
                 i, r, rs, {grant, sel, dout, dout_valid, done}, exp_v);
      else n_pass++;
      n_chk++;
      if (!$onehot0(grant) || dout_valid !== (|grant) || (grant != 0 && !grant[sel]))
        $display("FAIL rand_inv cyc%0d: got g=%b s=%0d v=%b want consistent", i, grant, sel, dout_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_five();
    test_early_release();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
